// File: rtl/fu_scheduler_if.sv
// Bundle of requester-side and functional-unit-side signals of fu_scheduler.
// The scheduler connects through the slave modport; the environment that
// drives requests and models the arithmetic units uses the master modport.
interface fu_scheduler_if #(
  parameter int unsigned N_REQ = 4
);
  // requester side
  logic [N_REQ-1:0]   req_bi;
  logic [2*N_REQ-1:0] op_bi;
  logic [8*N_REQ-1:0] a_bi;
  logic [8*N_REQ-1:0] b_bi;
  logic [N_REQ-1:0]   gnt_bo;
  logic [N_REQ-1:0]   done_bo;
  logic [15:0]        y_bo;
  logic               err_o;
  logic               busy_o;
  // functional-unit side
  logic [7:0]         fu_a_bo;
  logic [7:0]         fu_b_bo;
  logic [2:0]         fu_start_bo;
  logic [2:0]         fu_busy_bi;
  logic [15:0]        mul_y_bi;
  logic [7:0]         sqrt_y_bi;
  logic [7:0]         cube_y_bi;

  modport master (
    output req_bi, op_bi, a_bi, b_bi,
    output fu_busy_bi, mul_y_bi, sqrt_y_bi, cube_y_bi,
    input  gnt_bo, done_bo, y_bo, err_o, busy_o,
    input  fu_a_bo, fu_b_bo, fu_start_bo
  );

  modport slave (
    input  req_bi, op_bi, a_bi, b_bi,
    input  fu_busy_bi, mul_y_bi, sqrt_y_bi, cube_y_bi,
    output gnt_bo, done_bo, y_bo, err_o, busy_o,
    output fu_a_bo, fu_b_bo, fu_start_bo
  );
endinterface

// File: rtl/fu_scheduler.sv
// Round-robin scheduler sharing one mul, one sqrt and one cube unit among
// N_REQ requesters. One operation in flight; start pulse, busy handshake with
// acknowledge and run watchdogs, zero-extended result with a done pulse.
module fu_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input logic          clk_i,
  input logic          rst_i,
  fu_scheduler_if.slave bus
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, ACK, RUN, RESP} state_e;
  typedef enum logic [1:0] {OP_MUL = 2'd0, OP_SQRT = 2'd1, OP_CUBE = 2'd2, OP_RSVD = 2'd3} op_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  op_e               op_q, op_d;
  logic [7:0]        a_q, a_d;
  logic [7:0]        b_q, b_d;
  logic [15:0]       y_q, y_d;
  logic              err_q, err_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [WW-1:0]     wdog_q, wdog_d;
  logic              ack_q, ack_d;

  logic              sel_found;
  logic [PW-1:0]     sel_idx;
  logic [PW-1:0]     cand;
  logic [1:0]        sel_op;
  logic [7:0]        sel_a;
  logic [7:0]        sel_b;
  logic              unit_busy;
  logic [15:0]       unit_y;
  logic [2:0]        start;

  // Round-robin pick: first requesting index after ptr_q, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = PW'((32'(ptr_q) + i) % N_REQ);
      if (!sel_found && bus.req_bi[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Opcode/operand slice of the selected requester.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (sel_idx == PW'(k)) begin
        sel_op = bus.op_bi[2*k +: 2];
        sel_a  = bus.a_bi[8*k +: 8];
        sel_b  = bus.b_bi[8*k +: 8];
      end
    end
  end

  // Busy/result of the unit addressed by the captured opcode.
  always_comb begin
    unit_busy = 1'b0;
    unit_y    = '0;
    unique case (op_q)
      OP_MUL:  begin unit_busy = bus.fu_busy_bi[0]; unit_y = bus.mul_y_bi;            end
      OP_SQRT: begin unit_busy = bus.fu_busy_bi[1]; unit_y = {8'h00, bus.sqrt_y_bi};  end
      OP_CUBE: begin unit_busy = bus.fu_busy_bi[2]; unit_y = {8'h00, bus.cube_y_bi};  end
      default: ;
    endcase
  end

  // Next-state and register updates for the capture/issue/handshake sequence.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    err_d   = err_q;
    ptr_d   = ptr_q;
    wdog_d  = wdog_q;
    ack_d   = ack_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          gnt_d          = '0;
          gnt_d[sel_idx] = 1'b1;
          op_d           = op_e'(sel_op);
          a_d            = sel_a;
          b_d            = sel_b;
          ptr_d          = sel_idx;
          if (op_e'(sel_op) == OP_RSVD) begin
            err_d   = 1'b1;
            y_d     = '0;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        ack_d   = 1'b0;
        state_d = ACK;
      end
      ACK: begin
        if (unit_busy) begin
          state_d = RUN;
        end else if (ack_q) begin
          err_d   = 1'b1;
          y_d     = '0;
          state_d = RESP;
        end else begin
          ack_d = 1'b1;
        end
      end
      RUN: begin
        if (!unit_busy) begin
          y_d     = unit_y;
          state_d = RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
          if (wdog_d == WW'(TIMEOUT)) begin
            err_d   = 1'b1;
            y_d     = '0;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        gnt_d   = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      op_q    <= OP_MUL;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      ptr_q   <= PW'(N_REQ - 1);
      wdog_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
      ack_q   <= ack_d;
    end
  end

  // One-cycle start pulse to the addressed unit while in ISSUE.
  always_comb begin
    start = '0;
    if (state_q == ISSUE) begin
      unique case (op_q)
        OP_MUL:  start[0] = 1'b1;
        OP_SQRT: start[1] = 1'b1;
        OP_CUBE: start[2] = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.gnt_bo      = gnt_q;
  assign bus.done_bo     = (state_q == RESP) ? gnt_q : '0;
  assign bus.y_bo        = y_q;
  assign bus.err_o       = err_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.fu_a_bo     = a_q;
  assign bus.fu_b_bo     = b_q;
  assign bus.fu_start_bo = start;

endmodule

// File: tb/tb_fu_scheduler.sv
// Bench for fu_scheduler: behavioural unit stubs, scoreboard of expected
// responses per requester, and a round-robin reference model in the monitor.
module tb_fu_scheduler;
  localparam int N  = 4;
  localparam int TO = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fu_scheduler_if #(.N_REQ(N)) bus ();

  fu_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] y;
    logic        err;
    int          lo;
    int          hi;
  } exp_t;

  exp_t exp_q[N][$];
  int   vectors    = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int icbrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // ---------------- functional-unit stubs ----------------
  int          mode   = 0;   // 0 normal, 1 never busy, 2 busy stuck high
  int          lat_lo = 1;
  int          lat_hi = 4;
  int          ucnt[3];
  logic [15:0] mres;
  logic [7:0]  sres, cres;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 3; u++) ucnt[u] <= 0;
      mres <= '0;
      sres <= '0;
      cres <= '0;
    end else begin
      for (int u = 0; u < 3; u++) begin
        if (bus.fu_start_bo[u]) ucnt[u] <= $urandom_range(lat_hi, lat_lo);
        else if (ucnt[u] != 0)  ucnt[u] <= ucnt[u] - 1;
      end
      if (bus.fu_start_bo[0]) mres <= 16'(int'(bus.fu_a_bo) * int'(bus.fu_b_bo));
      if (bus.fu_start_bo[1]) sres <= 8'(isqrt(int'(bus.fu_a_bo)));
      if (bus.fu_start_bo[2]) cres <= 8'(icbrt(int'(bus.fu_a_bo)));
    end
  end

  always_comb begin
    for (int u = 0; u < 3; u++)
      bus.fu_busy_bi[u] = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (ucnt[u] != 0);
    bus.mul_y_bi  = mres;
    bus.sqrt_y_bi = sres;
    bus.cube_y_bi = cres;
  end

  // ---------------- monitor / reference model ----------------
  bit          m_idle = 1'b1;
  bit          m_idle_pend = 1'b0;
  int          mptr = N - 1;
  int          m_winner = -1;
  bit          gnt_pend = 1'b0;
  int          starts = 0;
  int          cyc = 0;
  int          gnt_cyc = 0;
  int          done_cnt[N];
  int          order_log[$];
  logic [15:0] last_y;
  logic        last_err;

  always @(negedge clk) begin
    exp_t e;
    int   w;
    if (!rst_n) begin
      m_idle      = 1'b1;
      m_idle_pend = 1'b0;
      mptr        = N - 1;
      m_winner    = -1;
      gnt_pend    = 1'b0;
      starts      = 0;
    end else begin
      cyc++;
      if (m_idle_pend) begin
        m_idle      = 1'b1;
        m_idle_pend = 1'b0;
      end
      if (gnt_pend) begin
        check("grant", 32'(bus.gnt_bo), 32'(1) << m_winner);
        gnt_pend = 1'b0;
        gnt_cyc  = cyc;
        starts   = 0;
      end
      check("busy_o", 32'(bus.busy_o), 32'(!m_idle));
      if (bus.fu_start_bo != 3'b000) begin
        starts++;
        if (!m_idle && m_winner >= 0 && exp_q[m_winner].size() > 0) begin
          e = exp_q[m_winner][0];
          check("start_bit", 32'(bus.fu_start_bo), 32'(1) << e.op);
          check("fu_a", 32'(bus.fu_a_bo), 32'(e.a));
          if (e.op == 2'd0) check("fu_b", 32'(bus.fu_b_bo), 32'(e.b));
        end else begin
          check("stray_start", 32'(bus.fu_start_bo), 32'(0));
        end
      end
      if (bus.done_bo != '0) begin
        if (m_idle || m_winner < 0) begin
          check("unexpected_done", 32'(bus.done_bo), 32'(0));
        end else begin
          check("done_onehot", 32'(bus.done_bo), 32'(1) << m_winner);
          if (exp_q[m_winner].size() == 0) begin
            check("done_without_request", 32'(bus.done_bo), 32'(0));
          end else begin
            e = exp_q[m_winner].pop_front();
            check("y_bo", 32'(bus.y_bo), 32'(e.y));
            check("err_o", 32'(bus.err_o), 32'(e.err));
            check("start_count", 32'(starts), (e.op == 2'd3) ? 32'(0) : 32'(1));
            check("latency_in_range", 32'((cyc - gnt_cyc) >= e.lo && (cyc - gnt_cyc) <= e.hi), 32'(1));
          end
          last_y   = bus.y_bo;
          last_err = bus.err_o;
          done_cnt[m_winner]++;
          order_log.push_back(m_winner);
          m_idle_pend = 1'b1;
        end
      end
      if (m_idle && bus.req_bi != '0) begin
        w = -1;
        for (int i = 1; i <= N; i++) begin
          if (w < 0 && bus.req_bi[(mptr + i) % N]) w = (mptr + i) % N;
        end
        mptr     = w;
        m_winner = w;
        m_idle   = 1'b0;
        gnt_pend = 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  bit outstanding[N];
  int seen[N];

  task automatic issue(input int k, input int op, input int a, input int b);
    exp_t e;
    e.op = 2'(op);
    e.a  = 8'(a);
    e.b  = 8'(b);
    if (op == 3) begin
      e.y = '0; e.err = 1'b1; e.lo = 0; e.hi = 2;
    end else if (mode == 1) begin
      e.y = '0; e.err = 1'b1; e.lo = 2; e.hi = 4;
    end else if (mode == 2) begin
      e.y = '0; e.err = 1'b1; e.lo = TO; e.hi = TO + 4;
    end else begin
      e.err = 1'b0; e.lo = 2; e.hi = lat_hi + 4;
      case (op)
        0:       e.y = 16'(a * b);
        1:       e.y = 16'(isqrt(a));
        default: e.y = 16'(icbrt(a));
      endcase
    end
    exp_q[k].push_back(e);
    bus.req_bi[k]        = 1'b1;
    bus.op_bi[2*k +: 2]  = 2'(op);
    bus.a_bi[8*k +: 8]   = 8'(a);
    bus.b_bi[8*k +: 8]   = 8'(b);
    outstanding[k]       = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (outstanding[k] && done_cnt[k] != seen[k]) begin
        seen[k]        = done_cnt[k];
        outstanding[k] = 1'b0;
        bus.req_bi[k]  = 1'b0;
      end
    end
  endtask

  function automatic logic [N-1:0] out_mask();
    logic [N-1:0] m = '0;
    for (int k = 0; k < N; k++) m[k] = outstanding[k];
    return m;
  endfunction

  task automatic wait_all(input int budget);
    int n = 0;
    while (out_mask() != '0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_outstanding", 32'(out_mask()), 32'(0));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"},   32'(bus.gnt_bo),      32'(0));
    check({tag, "_done"},  32'(bus.done_bo),     32'(0));
    check({tag, "_y"},     32'(bus.y_bo),        32'(0));
    check({tag, "_err"},   32'(bus.err_o),       32'(0));
    check({tag, "_busy"},  32'(bus.busy_o),      32'(0));
    check({tag, "_start"}, 32'(bus.fu_start_bo), 32'(0));
    check({tag, "_fua"},   32'(bus.fu_a_bo),     32'(0));
    check({tag, "_fub"},   32'(bus.fu_b_bo),     32'(0));
  endtask

  task automatic clear_driver();
    for (int k = 0; k < N; k++) begin
      outstanding[k] = 1'b0;
      seen[k]        = done_cnt[k];
      exp_q[k].delete();
    end
    bus.req_bi = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    clear_driver();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int base, n, cnt[N];
    bus.req_bi = '0;
    bus.op_bi  = '0;
    bus.a_bi   = '0;
    bus.b_bi   = '0;
    for (int k = 0; k < N; k++) begin
      done_cnt[k] = 0;
      seen[k]     = 0;
      outstanding[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    #1;
    rst_n = 1'b1;
    tick();

    // directed: mul, sqrt, cube
    issue(0, 0, 13, 11);
    wait_all(100);
    check("mul_13x11", 32'(last_y), 32'(143));
    check("mul_err", 32'(last_err), 32'(0));
    issue(2, 1, 64, 0);
    wait_all(100);
    check("sqrt_64", 32'(last_y), 32'(8));
    issue(2, 2, 27, 0);
    wait_all(100);
    check("cube_27", 32'(last_y), 32'(3));

    // round robin among 0,1,3 from reset, requests held through done
    do_reset();
    tick();
    base = order_log.size();
    for (int k = 0; k < N; k++) cnt[k] = 0;
    n = 0;
    while ((cnt[0] < 3 || cnt[1] < 3 || cnt[3] < 3 || out_mask() != '0) && n < 400) begin
      for (int k = 0; k < N; k++) begin
        if (k != 2 && !outstanding[k] && cnt[k] < 3) begin
          issue(k, int'($urandom_range(2, 0)), int'($urandom_range(255, 0)), int'($urandom_range(255, 0)));
          cnt[k]++;
        end
      end
      tick();
      n++;
    end
    check("rr_ops_done", 32'(order_log.size() - base), 32'(9));
    for (int i = 0; i < 9 && base + i < order_log.size(); i++)
      check("rr_order", 32'(order_log[base + i]), (i % 3 == 2) ? 32'(3) : 32'(i % 3));

    // reserved opcode
    issue(1, 3, 1, 2);
    wait_all(20);
    check("rsvd_err", 32'(last_err), 32'(1));
    check("rsvd_y", 32'(last_y), 32'(0));

    // unit never acknowledges, then unit busy stuck high
    mode = 1;
    issue(0, 0, 5, 5);
    wait_all(20);
    check("noack_err", 32'(last_err), 32'(1));
    mode = 2;
    issue(3, 1, 9, 0);
    wait_all(200);
    check("timeout_err", 32'(last_err), 32'(1));
    mode = 0;
    tick();

    // random traffic, with operand scrambling and request withdrawal after grant
    for (int c = 0; c < 400; c++) begin
      if (!m_idle && m_winner >= 0 && outstanding[m_winner] && $urandom_range(3, 0) == 0) begin
        bus.op_bi[2*m_winner +: 2] = 2'($urandom);
        bus.a_bi[8*m_winner +: 8]  = 8'($urandom);
        bus.b_bi[8*m_winner +: 8]  = 8'($urandom);
        if ($urandom_range(1, 0) == 0) bus.req_bi[m_winner] = 1'b0;
      end
      for (int k = 0; k < N; k++) begin
        if (!outstanding[k] && $urandom_range(2, 0) == 0)
          issue(k, ($urandom_range(7, 0) == 0) ? 3 : int'($urandom_range(2, 0)),
                int'($urandom_range(255, 0)), int'($urandom_range(255, 0)));
      end
      tick();
    end
    wait_all(600);

    // reset in the middle of a long mul, then pointer restarts at requester 0
    lat_lo = 12;
    lat_hi = 12;
    issue(2, 0, 200, 3);
    n = 0;
    while (!(m_winner == 2 && !m_idle && starts > 0) && n < 20) begin
      tick();
      n++;
    end
    check("midop_started", 32'(starts), 32'(1));
    repeat (3) tick();
    check("midop_busy", 32'(bus.busy_o), 32'(1));
    do_reset();
    lat_lo = 1;
    lat_hi = 4;
    tick();
    base = order_log.size();
    issue(1, 0, 7, 6);
    issue(3, 1, 100, 0);
    wait_all(100);
    check("post_rst_ops", 32'(order_log.size() - base), 32'(2));
    if (order_log.size() >= base + 2) begin
      check("post_rst_first", 32'(order_log[base]), 32'(1));
      check("post_rst_second", 32'(order_log[base + 1]), 32'(3));
    end
    check("post_rst_last_y", 32'(last_y), 32'(10));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

endmodule
